// File: rtl/fft_pkg.sv
// fft_pkg: shared sample width and butterfly mode encodings for the FFT stages
package fft_pkg;
  localparam int DATA_W = 24;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TWID = 2'b10,
    ST_BFLY = 2'b01
  } bf_state_e;
endpackage

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: DEPTH-entry shift FIFO with enable and synchronous clear; head is the oldest entry
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = 2 * DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= din;
    end
  end
  assign head = mem_q[0];
endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: radix-2 single-delay-feedback stage controller (counter, delay line, operand steering, output register)
// SDF_FLUSH_EN adds flush/flush_busy to drain the last half-frame with internal zero samples.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
`ifdef SDF_FLUSH_EN
  input  logic                     flush,
  output logic                     flush_busy,
`endif
  output logic [1:0]               bf_state,
  output logic signed [DATA_W-1:0] bf_a_r,
  output logic signed [DATA_W-1:0] bf_a_i,
  output logic signed [DATA_W-1:0] bf_b_r,
  output logic signed [DATA_W-1:0] bf_b_i,
  input  logic signed [DATA_W-1:0] bf_delay_r,
  input  logic signed [DATA_W-1:0] bf_delay_i,
  input  logic signed [DATA_W-1:0] bf_op_r,
  input  logic signed [DATA_W-1:0] bf_op_i,
  input  logic                     bf_outvalid,
  output logic [AW-1:0]            w_idx,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i,
  output logic                     dout_valid
);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(2 * DEPTH - 1);
  logic [AW:0] cnt_q, cnt_d;
  logic primed_q, primed_d, dv_q, dv_d, adv, wrap, flush_done;
  logic signed [DATA_W-1:0] s_r, s_i, dout_r_q, dout_i_q, dout_r_d, dout_i_d;
  logic [2*DATA_W-1:0] head;
  logic signed [DATA_W-1:0] head_r, head_i;
  bf_state_e st;
`ifdef SDF_FLUSH_EN
  logic busy_q, busy, flush_go;
  assign flush_go   = flush & ~busy_q & primed_q & (cnt_q == '0);
  assign busy       = busy_q | flush_go;
  assign flush_done = busy & (cnt_q == (AW+1)'(DEPTH - 1));
  assign flush_busy = busy;
  // while draining, external samples are ignored and zeros are fed in their place
  assign adv = busy | din_valid;
  assign s_r = busy ? '0 : din_r;
  assign s_i = busy ? '0 : din_i;
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else busy_q <= busy & ~flush_done;
  end
`else
  assign flush_done = 1'b0;
  assign adv = din_valid;
  assign s_r = din_r;
  assign s_i = din_i;
`endif
  sdf_delay_line #(.DEPTH(DEPTH), .W(2 * DATA_W)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  ({bf_delay_r, bf_delay_i}),
    .head (head)
  );
  assign head_r = head[2*DATA_W-1:DATA_W];
  assign head_i = head[DATA_W-1:0];
  assign wrap = adv & (cnt_q == CNT_LAST);
  always_comb begin
    cnt_d    = flush_done ? '0 : wrap ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    primed_d = ~flush_done & (primed_q | wrap);
    dv_d     = bf_outvalid & ((st == ST_BFLY) | primed_q);
    dout_r_d = dv_d ? bf_op_r : dout_r_q;
    dout_i_d = dv_d ? bf_op_i : dout_i_q;
  end
  always_comb begin
    st     = !adv ? ST_IDLE : cnt_q[AW] ? ST_BFLY : ST_TWID;
    bf_a_r = cnt_q[AW] ? s_r : head_r;
    bf_a_i = cnt_q[AW] ? s_i : head_i;
    bf_b_r = cnt_q[AW] ? head_r : s_r;
    bf_b_i = cnt_q[AW] ? head_i : s_i;
    w_idx  = (st == ST_TWID) ? cnt_q[AW-1:0] : '0;
  end
  assign bf_state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      dv_q     <= 1'b0;
      dout_r_q <= '0;
      dout_i_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      dv_q     <= dv_d;
      dout_r_q <= dout_r_d;
      dout_i_q <= dout_i_d;
    end
  end
  assign dout_r     = dout_r_q;
  assign dout_i     = dout_i_q;
  assign dout_valid = dv_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: directed bench for sdf_stage_ctrl (DEPTH=4) with a behavioural Q8 butterfly and unity twiddles
module tb_sdf_stage_ctrl;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0, bf_outvalid, dout_valid;
  logic signed [23:0] din_r = '0, din_i = '0;
  logic signed [23:0] bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_delay_r, bf_delay_i, bf_op_r, bf_op_i;
  logic signed [23:0] dout_r, dout_i;
  logic [1:0] bf_state;
  logic [AW-1:0] w_idx;
  logic signed [47:0] m_r, m_i;
  logic signed [23:0] tw_r, tw_i;
`ifdef SDF_FLUSH_EN
  logic flush = 1'b0, flush_busy;
`endif
  int n_chk = 0, n_pass = 0;
  int got_q[$], exp_q[$];

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_r(din_r), .din_i(din_i),
`ifdef SDF_FLUSH_EN
    .flush(flush), .flush_busy(flush_busy),
`endif
    .bf_state(bf_state), .bf_a_r(bf_a_r), .bf_a_i(bf_a_i), .bf_b_r(bf_b_r), .bf_b_i(bf_b_i),
    .bf_delay_r(bf_delay_r), .bf_delay_i(bf_delay_i), .bf_op_r(bf_op_r), .bf_op_i(bf_op_i),
    .bf_outvalid(bf_outvalid), .w_idx(w_idx), .dout_r(dout_r), .dout_i(dout_i), .dout_valid(dout_valid)
  );

  // butterfly: pass/twiddle in 10 (delay <- b, out <- a*w), add/sub in 01 (out <- b+a, delay <- b-a)
  always_comb begin
    tw_r = 24'sd256;
    tw_i = 24'sd0;
    m_r = 48'(bf_a_r) * 48'(tw_r) - 48'(bf_a_i) * 48'(tw_i);
    m_i = 48'(bf_a_r) * 48'(tw_i) + 48'(bf_a_i) * 48'(tw_r);
    bf_outvalid = bf_state != 2'b00;
    bf_op_r = 24'(m_r >>> 8);
    bf_op_i = 24'(m_i >>> 8);
    bf_delay_r = bf_b_r;
    bf_delay_i = bf_b_i;
    if (bf_state == 2'b01) begin
      bf_op_r = bf_b_r + bf_a_r;
      bf_op_i = bf_b_i + bf_a_i;
      bf_delay_r = bf_b_r - bf_a_r;
      bf_delay_i = bf_b_i - bf_a_i;
    end
  end

  always @(negedge clk) if (dout_valid) got_q.push_back(int'(dout_r));

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic send(input int xr);
    @(negedge clk);
    din_valid = 1'b1;
    din_r = 24'(xr);
    din_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic frame(input bit gap, input bit tw);
    for (int k = 0; k < 8; k++) begin
      send((k + 1) * 256);
      if (tw) begin
        #1;
        chk("state", int'(bf_state), k < 4 ? 2 : 1);
        chk("w_idx", int'(w_idx), k < 4 ? k : 0);
      end
      if (gap) begin
        @(negedge clk);
        din_valid = 1'b0;
        #1 chk("gap_state", int'(bf_state), 0);
      end
    end
    idle(1);
  endtask

  task automatic exp_frame(input bit primed);
    if (primed) repeat (4) exp_q.push_back(-1024);
    exp_q.push_back(1536);
    exp_q.push_back(2048);
    exp_q.push_back(2560);
    exp_q.push_back(3072);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dv", int'(dout_valid), 0);
    chk("rst_dout", int'(dout_r), 0);
    chk("rst_state", int'(bf_state), 0);
    got_q.delete();
  endtask

  initial begin
    do_reset();
    // two continuous frames: sums first, then twiddled differences ahead of the next sums
    frame(1'b0, 1'b0);
    idle(2);
    exp_frame(1'b0);
    cmp_q("frame1");
    frame(1'b0, 1'b1);
    idle(2);
    exp_frame(1'b1);
    cmp_q("frame2");
    // same streams with a gap after every sample
    do_reset();
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    idle(2);
    exp_frame(1'b0);
    exp_frame(1'b1);
    cmp_q("gapped");
    // mid-frame reset, asserted together with din_valid
    for (int k = 0; k < 3; k++) send(5000 + k);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b1;
    din_r = 24'sd777;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("midrst_dv", int'(dout_valid), 0);
    chk("midrst_dout", int'(dout_r), 0);
    got_q.delete();
    frame(1'b0, 1'b0);
    idle(2);
    exp_frame(1'b0);
    cmp_q("after_rst");
`ifdef SDF_FLUSH_EN
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      flush = (k == 0);
      din_valid = 1'b1;
      din_r = 24'sd999;
      #1 chk("flush_busy", int'(flush_busy), k < 4 ? 1 : 0);
    end
    idle(2);
    repeat (4) exp_q.push_back(-1024);
    cmp_q("flush");
    frame(1'b0, 1'b0);
    idle(2);
    exp_frame(1'b0);
    cmp_q("post_flush");
    send(256);
    send(512);
    @(negedge clk);
    din_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_cnt2_busy", int'(flush_busy), 0);
    @(negedge clk);
    flush = 1'b0;
    idle(3);
    exp_q.push_back(-1024);
    exp_q.push_back(-1024);
    cmp_q("flush_ignored");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: delay-line length in samples (N/2 of the stage); power of two, 2..512.
REQ-002 Parameter AW, default $clog2(DEPTH): twiddle index width.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port din_valid  in  1: input sample strobe; the stage advances only on cycles where it is high.
REQ-006 Port din_r / din_i  in  24 each: signed input sample.
REQ-007 Port bf_state  out  2: butterfly mode, 00 idle, 10 pass/twiddle, 01 add/sub.
REQ-008 Port bf_a_r / bf_a_i / bf_b_r / bf_b_i  out  24 each: signed butterfly operands.
REQ-009 Port bf_delay_r / bf_delay_i  in  24 each: signed butterfly feedback value written into the delay line.
REQ-010 Port bf_op_r / bf_op_i  in  24 each: signed butterfly result.
REQ-011 Port bf_outvalid  in  1: butterfly result strobe.
REQ-012 Port w_idx  out  AW: twiddle ROM address.
REQ-013 Port dout_r / dout_i  out  24 each: signed stage output, registered.
REQ-014 Port dout_valid  out  1: stage output strobe, registered.

Function
REQ-015 Sample counter cnt (AW+1 bits) SHALL increment on each din_valid and wrap from 2*DEPTH-1 to 0.
REQ-016 bf_state SHALL be 00 when din_valid=0, 10 when din_valid=1 and cnt<DEPTH, and 01 when din_valid=1 and cnt>=DEPTH.
REQ-017 In state 10: bf_a = delay-line head, bf_b = din, w_idx = cnt[AW-1:0].
REQ-018 In state 01: bf_a = din, bf_b = delay-line head, w_idx = 0.
REQ-019 On each din_valid, the delay line SHALL pop its head and push bf_delay (a FIFO of exactly DEPTH entries); it SHALL hold when din_valid=0.
REQ-020 Flag primed SHALL set when cnt wraps from 2*DEPTH-1 to 0 and stay set until reset.
REQ-021 dout_valid SHALL equal the previous cycle's bf_outvalid & (bf_state==01 | primed), giving 1-cycle latency, with dout = bf_op registered on the same edge.
REQ-022 When dout_valid=0, dout SHALL hold its last value.
REQ-023 Data SHALL pass unmodified at 24 bits; the block performs no arithmetic, and scaling belongs to the butterfly.
REQ-024 Gaps in din_valid of any length SHALL NOT alter results; output order equals the order of the gap-free stream.

Reset
REQ-025 On rst: cnt=0, primed=0, all DEPTH delay entries=0, dout_r/dout_i=0, dout_valid=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the first din_valid after rst is sample k=0 of a new frame.
REQ-027 rst SHALL take priority over din_valid in the same cycle.

Configuration
REQ-028 Macro SDF_FLUSH_EN.
- Defined: adds ports flush (in, 1) and flush_busy (out, 1).
- A flush pulse with cnt==0 and primed=1 SHALL start DEPTH internal zero-valued valid samples in state 10, emitting the last frame's twiddled differences.
- flush_busy=1 during that time; din_valid is ignored while busy.
- primed clears on completion.
- A flush pulse at any other time is ignored.
REQ-029 Macro undefined: no flush ports; the last half-frame emerges only when the next frame is input.

Structure
REQ-030 Shared package fft_pkg holds DATA_W=24 and the bf_state encodings ST_IDLE=2'b00, ST_TWID=2'b10, ST_BFLY=2'b01.
REQ-031 One sub-module, sdf_delay_line (DEPTH x 48-bit FIFO with enable and synchronous clear), instantiated once.

Verification
(Bench instantiates the butterfly with a Q8 twiddle model, unity = (256,0), and DEPTH=4.)
REQ-032 Frame x=1..8 (x256, imag 0), continuous valid -> first dout at the 5th sample: 1536,2048,2560,3072, then dout_valid low for the next frame's first 4 samples' predecessors; no output while primed=0 in state 10.
REQ-033 Second frame of any data after REQ-032 with unity twiddles -> first 4 douts = -1024 each (twiddled differences), w_idx sequence 0,1,2,3.
REQ-034 Same streams with din_valid on alternate cycles -> identical dout sequence; bf_state=00 on gap cycles.
REQ-035 rst pulse after 3 samples of a frame, then x=1..8 -> outputs as in REQ-032; dout_valid=0 and dout=0 in the cycle after rst.
REQ-036 SDF_FLUSH_EN build: after REQ-032, flush at cnt==0 -> flush_busy high 4 cycles, 4 douts of -1024, primed=0 afterwards; flush issued with cnt=2 -> no effect.
